// File: rtl/ksa_wide_add_seq.sv
// Multi-cycle WIDTH-bit adder that streams byte slices through one 8-bit Kogge-Stone adder (ksa_1).
// Optional subtract mode is enabled by defining KSA_SUB_EN (adds port op_sub).

module ksa_1 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  logic [7:0] w_g0, w_p0, w_g1, w_p1, w_g2, w_p2, w_g3, w_p3;
  logic [8:0] w_c;

  // Bit-parallel prefix levels at distances 1, 2, 4; lanes below the distance keep their group terms.
  always_comb begin
    w_g0 = a & b;
    w_p0 = a ^ b;
    w_g1 = w_g0 | (w_p0 & (w_g0 << 1));
    w_p1 = w_p0 & ((w_p0 << 1) | 8'h01);
    w_g2 = w_g1 | (w_p1 & (w_g1 << 2));
    w_p2 = w_p1 & ((w_p1 << 2) | 8'h03);
    w_g3 = w_g2 | (w_p2 & (w_g2 << 4));
    w_p3 = w_p2 & ((w_p2 << 4) | 8'h0F);
    w_c  = {w_g3 | (w_p3 & {8{cin}}), cin};
    sum  = w_p0 ^ w_c[7:0];
    cout = w_c[8];
  end
endmodule

module ksa_wide_add_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef KSA_SUB_EN
  input  logic             op_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int SLICES = WIDTH / 8;
  localparam int CW     = (SLICES > 1) ? $clog2(SLICES) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t           r_state, w_next_state;
  logic [WIDTH-1:0] r_a_sh, r_b_sh, r_acc, r_sum, w_acc_next;
  logic [CW-1:0]    r_count;
  logic             r_carry, r_cout, w_last, w_ksa_cout;
  logic [7:0]       w_b_slice, w_ksa_sum;
`ifdef KSA_SUB_EN
  logic             r_sub;
  assign w_b_slice = r_sub ? ~r_b_sh[7:0] : r_b_sh[7:0];
`else
  assign w_b_slice = r_b_sh[7:0];
`endif

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign w_last    = (r_count == CW'(SLICES - 1));

  ksa_1 u_ksa_1 (
    .a    (r_a_sh[7:0]),
    .b    (w_b_slice),
    .cin  (r_carry),
    .sum  (w_ksa_sum),
    .cout (w_ksa_cout)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) w_next_state = S_RUN;
        else          w_next_state = S_IDLE;
      end
      S_RUN: begin
        if (w_last) w_next_state = S_DONE;
        else        w_next_state = S_RUN;
      end
      S_DONE: begin
        if (out_ready) w_next_state = S_IDLE;
        else           w_next_state = S_DONE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Merge the current slice result into the partial sum at position r_count
  always_comb begin
    w_acc_next = r_acc;
    for (int i = 0; i < SLICES; i++) begin
      if (r_count == CW'(i)) w_acc_next[i*8 +: 8] = w_ksa_sum;
      else                   w_acc_next[i*8 +: 8] = r_acc[i*8 +: 8];
    end
  end

  // Operand capture, per-slice pass, and result publication on the final pass only
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_carry <= 1'b0;
      r_count <= '0;
`ifdef KSA_SUB_EN
      r_sub   <= 1'b0;
`endif
    end else if (r_state == S_IDLE && in_valid) begin
      r_a_sh  <= a;
      r_b_sh  <= b;
      r_count <= '0;
`ifdef KSA_SUB_EN
      r_sub   <= op_sub;
      r_carry <= op_sub ? 1'b1 : cin;
`else
      r_carry <= cin;
`endif
    end else if (r_state == S_RUN) begin
      r_acc   <= w_acc_next;
      r_carry <= w_ksa_cout;
      r_a_sh  <= r_a_sh >> 8;
      r_b_sh  <= r_b_sh >> 8;
      r_count <= r_count + CW'(1);
      if (w_last) begin
        r_sum  <= w_acc_next;
        r_cout <= w_ksa_cout;
      end else begin
        r_sum  <= r_sum;
        r_cout <= r_cout;
      end
    end else begin
      r_acc <= r_acc;
    end
  end
endmodule
